md_sched: RTL and testbench
===========================

# md_sched

Sequencing controller for the multiply/divide resource in the pipelined MIPS core. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the EX stage and latches the operands. It runs each multi-cycle operation for a fixed latency, then commits the result to the HI/LO registers. It drives the `busy` status that the hazard unit uses to stall later MD instructions and MFHI/MFLO.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- `clk`, in, 1: single clock; all state changes on the posedge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: a request is present this cycle.
- `op`, in, 3: operation code. 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- `a`, in, 32: rs operand.
- `b`, in, 32: rt operand.
- `busy`, out, 1: a multi-cycle operation is in flight (registered).
- `done`, out, 1: one-cycle pulse in the cycle after a multi-cycle operation finishes.
- `hi`, out, 32: architectural HI register.
- `lo`, out, 32: architectural LO register.

## Operation
- States are IDLE and RUN. `busy` equals (state == RUN).
- Reset values, applied asynchronously: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, cycle counter 0, operand latches 0.

Accept and run:
- A request is accepted only in IDLE with `start` = 1.
- MULT, MULTU, DIV and DIVU latch `a`, `b` and `op`, load the counter with the matching latency, and enter RUN.
- In RUN the counter decrements every cycle.
- On the edge where the counter equals 1, the block commits HI/LO, returns to IDLE and sets `done` for one cycle.

Arithmetic:
- MULT: {hi, lo} = signed 64-bit product.
- MULTU: {hi, lo} = unsigned 64-bit product.
- DIV: lo = signed quotient truncated toward zero; hi = remainder, whose sign follows the dividend.
- DIVU: unsigned quotient in lo and unsigned remainder in hi.
- 0x80000000 / 0xFFFFFFFF under DIV gives lo = 0x80000000 and hi = 0.
- Divide by zero (DIV or DIVU): full DIV_CYCLES busy and `done` still pulse, but HI/LO are left unchanged.
- The result is computed from the latched operands only. Changes on `a`/`b` while in RUN have no effect.

Single-cycle writes:
- MTHI writes `a` into hi; MTLO writes `a` into lo.
- The write happens at the accepting edge with no busy period and no `done` pulse.

Rejected and null requests:
- Any `start` while in RUN is ignored, whatever the op. The pipeline guarantees a stall; this block neither queues nor errors.
- Opcodes 110 and 111 are accepted as no-ops: no state change.

Reset during RUN:
- Aborts the operation immediately.
- hi/lo return to 0, `busy` to 0, and no `done` pulse occurs.

## Timing
- Request accepted at edge E (`start` high in the cycle before E).
- `busy` is 1 for exactly N cycles after E, where N = MULT_CYCLES or DIV_CYCLES.
- The commit happens at edge E+N. New hi/lo are visible, `busy` = 0 and `done` = 1 during the cycle after E+N. `done` clears at E+N+1.
- A new request presented in that same cycle (`busy` = 0, `done` = 1) is accepted at E+N+1. Back-to-back throughput is therefore N+1 cycles per operation.
- MTHI/MTLO accepted at edge E: new value visible in the cycle after E.
- `busy`, `done`, `hi` and `lo` are all driven directly from flops; there is no combinational path from the inputs to the outputs.

## Test plan
- Reset with MULT: reset, then start MULT with a = 0xFFFFFFFE (-2), b = 3. Required: `busy` high 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, and `done` pulses once.
- Signed vs unsigned divide: DIV with a = -7, b = 2 gives lo = 0xFFFFFFFD, hi = 0xFFFFFFFF after 10 busy cycles. DIVU with a = 0xFFFFFFF9, b = 2 gives lo = 0x7FFFFFFC, hi = 1.
- Divide by zero: preload hi = 0x11 and lo = 0x22 via MTHI/MTLO (each visible the next cycle). DIVU with b = 0 must then show 10 busy cycles, a `done` pulse, and hi/lo still 0x11/0x22.
- Ignored requests during RUN: start MULT a = 3, b = 4. On cycle 2 of busy, present MTLO a = 0xDEAD and change `a`/`b`. Required: MTLO ignored; final hi = 0, lo = 12.
- Back-to-back: issue MULTU 0x10000 × 0x10000 and hold `start` high with a second MULTU 5 × 5. First result hi = 1, lo = 0. The second is accepted the cycle `done` is high; final lo = 25, hi = 0.
- Reset mid-operation: assert `reset` on busy cycle 4 of a DIV. Required: `busy`, hi and lo go to 0 immediately, with no `done` pulse afterward.

Source files
------------

// File: rtl/md_sched.sv
// ----------------------------------------------------------------------------
// md_sched -- multiply/divide sequencing controller for the MIPS EX stage.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests while idle, latches the
// operands of multi-cycle operations, holds `busy` for a fixed latency and
// then commits the result into the architectural HI/LO registers.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//
// Ports:
//   clk    in   1   clock, all state changes on posedge
//   reset  in   1   asynchronous active-high reset
//   start  in   1   request present this cycle
//   op     in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                   100 MTHI, 101 MTLO, 110/111 no-op
//   a      in  32   rs operand
//   b      in  32   rt operand
//   busy   out  1   multi-cycle operation in flight
//   done   out  1   one-cycle pulse after a multi-cycle operation commits
//   hi     out 32   architectural HI
//   lo     out 32   architectural LO
// ----------------------------------------------------------------------------
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } op_e;

   typedef enum logic {IDLE, RUN} state_e;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   state_e      state;
   logic [3:0]  cnt;
   logic [2:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] quo_u;
   logic [31:0] rem_u;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        signed_div;
   logic        div_zero;

   // `busy` is a direct decode of the single state flop.
   assign busy = (state == RUN);

   // Result datapath, driven only by the latched operands so that activity
   // on a/b during RUN cannot disturb the committed value.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      res_hi = '0;
      res_lo = '0;

      // The low 64 bits of the product of sign-extended operands equal the
      // signed 64-bit product.
      prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u = {32'b0, a_q} * {32'b0, b_q};

      // Signed divide runs on magnitudes and fixes signs afterwards. The
      // 0x80000000 / -1 case falls out naturally: its magnitude quotient is
      // 0x80000000 with a positive sign and a zero remainder.
      signed_div = (op_q == OP_DIV);
      div_zero   = (b_q == 32'b0);
      mag_a      = (signed_div && a_q[31]) ? -a_q : a_q;
      mag_b      = (signed_div && b_q[31]) ? -b_q : b_q;
      quo_u      = div_zero ? 32'b0 : mag_a / mag_b;
      rem_u      = div_zero ? 32'b0 : mag_a % mag_b;

      case (op_q)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            res_lo = (a_q[31] ^ b_q[31]) ? -quo_u : quo_u;
            res_hi = a_q[31] ? -rem_u : rem_u;
         end
         OP_DIVU: begin
            res_lo = quo_u;
            res_hi = rem_u;
         end
         default: ;
      endcase
   end

   // NOTE: all state here is sequential and uses non-blocking assignments so
   // every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= op[1] ? DIV_N : MULT_N;
                        state <= RUN;
                     end
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     default: ;  // 110/111: accepted, nothing happens
                  endcase
               end
            end
            RUN: begin
               // Requests arriving in RUN are dropped; the hazard unit stalls.
               if (cnt == 4'd1) begin
                  // op_q[1] marks DIV/DIVU; divide by zero keeps HI/LO.
                  if (!(op_q[1] && div_zero)) begin
                     hi <= res_hi;
                     lo <= res_lo;
                  end
                  cnt   <= '0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// ----------------------------------------------------------------------------
// tb_md_sched -- self-checking bench for md_sched.
//
// A table of multi-cycle operations (with HI/LO preloads) is applied in a
// loop, followed by hand-written sequences for reset, ignored requests,
// back-to-back issue, no-op opcodes and reset during RUN.
// ----------------------------------------------------------------------------
module tb_md_sched;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   md_sched #(
      .MULT_CYCLES(MC),
      .DIV_CYCLES (DC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .op   (op),
      .a    (a),
      .b    (b),
      .busy (busy),
      .done (done),
      .hi   (hi),
      .lo   (lo)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_n;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // MTHI (100) or MTLO (101); new value must be visible the next cycle.
   task automatic write_reg(input logic [2:0] wop, input logic [31:0] val);
      @(negedge clk);
      start = 1'b1; op = wop; a = val; b = 32'h0;
      @(negedge clk);
      start = 1'b0;
      if (wop == 3'b100) check("mthi value", 64'(hi), 64'(val));
      else               check("mtlo value", 64'(lo), 64'(val));
      check("mt no busy", 64'(busy), 64'(0));
   endtask

   // Count busy cycles starting at the current negedge, bounded.
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 40) begin
         cycles++;
         @(negedge clk);
      end
      if (cycles >= 40) check("busy timeout", 64'(1), 64'(0));
   endtask

   // Issue one request, then scramble the inputs so only latched operands count.
   task automatic run_op(input logic [2:0] rop, input logic [31:0] ra,
                         input logic [31:0] rb, output int cycles);
      @(negedge clk);
      start = 1'b1; op = rop; a = ra; b = rb;
      @(negedge clk);
      start = 1'b0; op = 3'b111; a = 32'h5A5A_5A5A; b = 32'h0F0F_0F0F;
      wait_idle(cycles);
   endtask

   initial begin
      int  cyc;
      bit  saw_done;

      //         op      a             b             pre_hi        pre_lo        exp_hi        exp_lo        n
      vecs[0] = '{3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
      vecs[1] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, MC};
      vecs[2] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, MC};
      vecs[3] = '{3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h3FFF_FFFF, 32'h0000_0001, MC};
      vecs[4] = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
      vecs[5] = '{3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFC, DC};
      vecs[6] = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFD, DC};
      vecs[7] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0055, 32'h0000_0066, 32'h0000_0000, 32'h8000_0000, DC};
      vecs[8] = '{3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 32'h0000_0011, 32'h0000_0022, DC};
      vecs[9] = '{3'b010, 32'hFFFF_FF00, 32'h0000_0000, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_00AA, 32'h0000_00BB, DC};

      // Reset state
      reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset hi",   64'(hi),   64'(0));
      check("reset lo",   64'(lo),   64'(0));
      reset = 1'b0;

      // Table-driven multi-cycle operations
      for (int i = 0; i < 10; i++) begin
         write_reg(3'b100, vecs[i].pre_hi);
         write_reg(3'b101, vecs[i].pre_lo);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
         check($sformatf("v%0d latency", i), 64'(cyc), 64'(vecs[i].exp_n));
         check($sformatf("v%0d done", i), 64'(done), 64'(1));
         check($sformatf("v%0d hi", i), 64'(hi), 64'(vecs[i].exp_hi));
         check($sformatf("v%0d lo", i), 64'(lo), 64'(vecs[i].exp_lo));
         @(negedge clk);
         check($sformatf("v%0d done clear", i), 64'(done), 64'(0));
      end

      // Requests during RUN are ignored; operand changes have no effect
      write_reg(3'b100, 32'h0);
      write_reg(3'b101, 32'h0);
      @(negedge clk);
      start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
      @(negedge clk);                // busy cycle 1
      start = 1'b0;
      @(negedge clk);                // busy cycle 2
      start = 1'b1; op = 3'b101; a = 32'hDEAD; b = 32'd99;
      @(negedge clk);
      start = 1'b0;
      wait_idle(cyc);
      check("ignore latency", 64'(cyc + 2), 64'(MC));
      check("ignore done", 64'(done), 64'(1));
      check("ignore hi", 64'(hi), 64'(0));
      check("ignore lo", 64'(lo), 64'(12));
      @(negedge clk);

      // Back-to-back: start held high, second request accepted in the done cycle
      start = 1'b1; op = 3'b001; a = 32'h0001_0000; b = 32'h0001_0000;
      @(negedge clk);
      a = 32'd5; b = 32'd5;
      wait_idle(cyc);
      check("b2b first latency", 64'(cyc), 64'(MC));
      check("b2b first done", 64'(done), 64'(1));
      check("b2b first hi", 64'(hi), 64'(1));
      check("b2b first lo", 64'(lo), 64'(0));
      @(negedge clk);
      start = 1'b0;
      check("b2b second accepted", 64'(busy), 64'(1));
      wait_idle(cyc);
      check("b2b second latency", 64'(cyc), 64'(MC));
      check("b2b second done", 64'(done), 64'(1));
      check("b2b second hi", 64'(hi), 64'(0));
      check("b2b second lo", 64'(lo), 64'(25));
      @(negedge clk);

      // Opcodes 110/111 are no-ops
      write_reg(3'b100, 32'h0000_0033);
      write_reg(3'b101, 32'h0000_0044);
      @(negedge clk);
      start = 1'b1; op = 3'b110; a = 32'hFFFF_FFFF; b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      check("nop busy", 64'(busy), 64'(0));
      check("nop hi", 64'(hi), 64'(32'h33));
      check("nop lo", 64'(lo), 64'(32'h44));
      @(negedge clk);
      check("nop no done", 64'(done), 64'(0));

      // Reset on busy cycle 4 of a DIV
      write_reg(3'b100, 32'h0000_0055);
      write_reg(3'b101, 32'h0000_0066);
      @(negedge clk);
      start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
      @(negedge clk);                // busy cycle 1
      start = 1'b0;
      repeat (3) @(negedge clk);     // busy cycle 4
      check("pre-abort busy", 64'(busy), 64'(1));
      reset = 1'b1;
      #1;
      check("abort busy", 64'(busy), 64'(0));
      check("abort hi", 64'(hi), 64'(0));
      check("abort lo", 64'(lo), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      check("abort no done", 64'(saw_done), 64'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
